spi_mem_master: RTL
===================

Name: spi_mem_master

Overview:
- Host-side controller for the single-wire serial memory slave (cs / miso-in / mosi-out / ready / op_done protocol).
- Arbitrates between N_REQ parallel requesters using round-robin.
- Serialises the winning read or write command onto the slave's input line and deserialises read data from its output line.
- Returns one response per accepted request. It is the only master of the memory's serial port.

Parameters:
N_REQ, 2, number of requesters (2..4)
MEM_DEPTH, 32, number of valid memory locations; addresses >= MEM_DEPTH are rejected
TIMEOUT, 64, max cycles waited for slave ready/op_done before error

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  N_REQ  per-requester request pending
req_we  input  N_REQ  1=write, 0=read (per requester)
req_addr  input  8*N_REQ  byte address, requester i at [8i+7:8i]
req_wdata  input  8*N_REQ  write data, requester i at [8i+7:8i]
req_ready  output  N_REQ  one-hot, 1-cycle accept pulse
rsp_valid  output  N_REQ  one-hot, 1-cycle response pulse to the owning requester
rsp_rdata  output  8  read data, valid with rsp_valid (0 for writes/errors)
rsp_err  output  1  valid with rsp_valid: address out of range or timeout
spi_cs  output  1  slave chip select, active low (drives slave cs)
spi_sdo  output  1  serial data to slave (drives slave miso)
spi_sdi  input  1  serial data from slave (slave mosi)
spi_ready  input  1  slave read-data-valid
spi_done  input  1  slave op_done
busy  output  1  FSM not in IDLE

Behaviour:
- Reset: state=IDLE, spi_cs=1, spi_sdo=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
- Reset applied mid-transaction aborts it with no response. The arbitration pointer resets to requester 0 having highest priority.
- All outputs are registered.
- Arbitration happens only in IDLE with any req_valid set.
  - Round-robin: search starts at the requester after the last granted one.
  - The winner gets req_ready for 1 cycle (acceptance cycle A). we/addr/wdata are latched at A.
  - Requester i holds its valid, we, addr and wdata stable until its req_ready is seen.
- Out-of-range address (addr >= MEM_DEPTH): no serial traffic. RESP is entered at A+1 with rsp_err=1 in cycle A+1.
- FSM states: IDLE, START, OPBIT, SHIFT, WAIT_RDY, CAPTURE, WAIT_DONE, RESP, GAP.
  - START (A+1): spi_cs=0, spi_sdo=we. This is the only cycle with spi_cs low.
  - OPBIT (A+2): spi_cs=1, spi_sdo=we.
  - SHIFT: one bit per cycle, LSB first, spi_cs=1.
    - Write shifts 16 bits: addr[7:0] then wdata[7:0].
    - Read shifts 8 bits: addr[7:0].
    - Shift counter is 5 bits.
  - Write: SHIFT -> WAIT_DONE.
  - Read: SHIFT -> WAIT_RDY.
  - WAIT_RDY: leave when spi_ready=1. That first cycle is CAPTURE bit 0.
  - CAPTURE: samples spi_sdi on 8 consecutive cycles starting with the first spi_ready=1 cycle, LSB first, into rdata[0..7]. Then -> WAIT_DONE.
  - WAIT_DONE: on spi_done=1 -> RESP.
  - RESP: rsp_valid[owner]=1 for 1 cycle with rsp_rdata/rsp_err. Then -> IDLE.
- Required latency, no error:
  - Write: rsp_valid at A+21.
  - Read: spi_ready first high at A+12; rsp_valid at A+22.
- Timeout: a counter runs in WAIT_RDY and WAIT_DONE and clears on state entry.
  - Reaching TIMEOUT -> RESP with rsp_err=1, rsp_rdata=0, then GAP.
  - GAP holds spi_cs=1 for 32 cycles before IDLE so the slave can drain.
- spi_sdo=0 whenever not in START/OPBIT/SHIFT.
- spi_done or spi_ready arriving outside WAIT_* or CAPTURE is ignored.
- A request arriving during a transaction waits. No request is dropped or duplicated.
- Back-to-back: next acceptance no earlier than the cycle after RESP. spi_cs stays high at least 3 cycles between START pulses.

Test Plan:
- Write req0 addr=0x05 wdata=0xA5 -> spi_cs low exactly 1 cycle; spi_sdo sequence 1,1,then bits of 0x05 and 0xA5 LSB first; rsp_valid[0] at A+21, rsp_err=0.
- Read req1 addr=0x05 after the write above -> spi_ready at A+12; rsp_valid[1] at A+22 with rsp_rdata=0xA5, rsp_err=0.
- Both requesters valid continuously, 4 writes each -> grants alternate 0,1,0,1…; every request gets exactly one rsp_valid to the correct requester.
- Read addr=0x20 -> no spi_cs low; rsp_valid at A+1 with rsp_err=1, rsp_rdata=0.
- Slave model never asserts spi_ready -> rsp_err=1 after TIMEOUT=64 cycles in WAIT_RDY; 32-cycle GAP; the next request then completes correctly.
- rst asserted during SHIFT of a write -> next cycle spi_cs=1, spi_sdo=0, busy=0, no rsp_valid; a subsequent read returns pre-existing memory contents.

Source files
------------

// File: rtl/spi_mem_master_if.sv
// Request/response bus between the requesters and the serial memory controller.
interface spi_mem_master_if #(
    parameter int unsigned N_REQ = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_we;
    logic [8*N_REQ-1:0] req_addr;
    logic [8*N_REQ-1:0] req_wdata;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   rsp_valid;
    logic [7:0]         rsp_rdata;
    logic               rsp_err;

    // Requester side
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Controller side
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/spi_mem_master.sv
// Round-robin arbiter plus serialiser for the single-wire serial memory slave.
// One transaction in flight; every accepted request gets exactly one response.
module spi_mem_master #(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned MEM_DEPTH = 32,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic            clk,
    input  logic            rst,
    spi_mem_master_if.slave bus,
    output logic            spi_cs,
    output logic            spi_sdo,
    input  logic            spi_sdi,
    input  logic            spi_ready,
    input  logic            spi_done,
    output logic            busy
);
    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CntW = $clog2(((TIMEOUT > 32) ? TIMEOUT : 32) + 1);

    typedef enum logic [3:0] {
        StIdle, StStart, StOpbit, StShift, StWaitRdy, StCapture, StWaitDone, StResp, StGap
    } state_t;

    state_t            state_q, state_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [IdxW-1:0]   last_q, last_d;
    logic              we_q, we_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [4:0]        bitcnt_q, bitcnt_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              tmo_q, tmo_d;

    logic [N_REQ-1:0]  req_ready_q, req_ready_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [7:0]        rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              spi_cs_q, spi_cs_d;
    logic              spi_sdo_q, spi_sdo_d;
    logic              busy_q, busy_d;

    logic              grant_found;
    logic [IdxW-1:0]   grant_idx;
    logic [15:0]       shift_data;

    assign shift_data = {wdata_q, addr_q};

    // Search starts one past the last winner.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_q;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            int unsigned cand;
            cand = (32'(last_q) + k) % N_REQ;
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = IdxW'(cand);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        bitcnt_d    = bitcnt_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_ready_q != '0) begin
                    // Acceptance cycle: request fields were latched on the grant edge.
                    if (32'(addr_q) >= MEM_DEPTH) begin
                        state_d              = StResp;
                        rsp_valid_d[owner_q] = 1'b1;
                        rsp_err_d            = 1'b1;
                    end else begin
                        state_d = StStart;
                    end
                end else if (grant_found) begin
                    req_ready_d[grant_idx] = 1'b1;
                    owner_d = grant_idx;
                    last_d  = grant_idx;
                    we_d    = bus.req_we[grant_idx];
                    addr_d  = bus.req_addr[8*grant_idx +: 8];
                    wdata_d = bus.req_wdata[8*grant_idx +: 8];
                    rdata_d = '0;
                    tmo_d   = 1'b0;
                end
            end
            StStart: state_d = StOpbit;
            StOpbit: begin
                state_d  = StShift;
                bitcnt_d = '0;
            end
            StShift: begin
                if (bitcnt_q == (we_q ? 5'd15 : 5'd7)) begin
                    state_d = we_q ? StWaitDone : StWaitRdy;
                    cnt_d   = '0;
                end else begin
                    bitcnt_d = bitcnt_q + 5'd1;
                end
            end
            StWaitRdy: begin
                if (spi_ready) begin
                    rdata_d[0] = spi_sdi;
                    bitcnt_d   = 5'd1;
                    state_d    = StCapture;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    state_d              = StResp;
                    tmo_d                = 1'b1;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_err_d            = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCapture: begin
                rdata_d[bitcnt_q[2:0]] = spi_sdi;
                if (bitcnt_q == 5'd7) begin
                    state_d = StWaitDone;
                    cnt_d   = '0;
                end else begin
                    bitcnt_d = bitcnt_q + 5'd1;
                end
            end
            StWaitDone: begin
                if (spi_done) begin
                    state_d              = StResp;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d          = rdata_q;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    state_d              = StResp;
                    tmo_d                = 1'b1;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_err_d            = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                // After a timeout the slave may still be mid-operation; let it drain.
                if (tmo_q) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StGap: begin
                if (cnt_q == CntW'(31)) state_d = StIdle;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase

        spi_cs_d = (state_d != StStart);
        busy_d   = (state_d != StIdle);
        unique case (state_d)
            StStart, StOpbit: spi_sdo_d = we_q;
            StShift:          spi_sdo_d = shift_data[bitcnt_d[3:0]];
            default:          spi_sdo_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            last_q      <= IdxW'(N_REQ - 1);
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            bitcnt_q    <= '0;
            cnt_q       <= '0;
            tmo_q       <= 1'b0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            spi_cs_q    <= 1'b1;
            spi_sdo_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            bitcnt_q    <= bitcnt_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            spi_cs_q    <= spi_cs_d;
            spi_sdo_q   <= spi_sdo_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign spi_cs        = spi_cs_q;
    assign spi_sdo       = spi_sdo_q;
    assign busy          = busy_q;
endmodule
